motor_pwm_driver: RTL and testbench

//  Downstream stage of the line-follower controller: turns per-wheel motor_*_reset/motor_*_direction into servo PWM.

---
 rtl/motor_pkg.sv | 26 ++
 rtl/pwm_channel.sv | 109 ++++++++++
 rtl/motor_pwm_driver.sv | 73 +++++++
 tb/tb_motor_pwm_driver.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared types and default timing constants for the servo PWM driver.
// Default frame timing assumes a 100 MHz clock (20 ms frame, 1.0/1.5/2.0 ms pulses).
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } chan_state_t;

  localparam int DEF_CNT_W      = 25;
  localparam int DEF_PERIOD     = 2_000_000;
  localparam int DEF_PULSE_FWD  = 200_000;
  localparam int DEF_PULSE_REV  = 100_000;
  localparam int DEF_PULSE_STOP = 150_000;
  localparam int DEF_RAMP_STEP  = 10_000;

  // Move cur toward tgt by at most step; lands exactly on tgt when close enough.
  function automatic int ramp_toward(input int cur, input int tgt, input int step);
    if (tgt > cur) begin
      return ((tgt - cur) > step) ? (cur + step) : tgt;
    end
    return ((cur - tgt) > step) ? (cur - step) : tgt;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One servo PWM channel: IDLE/HIGH/LOW frame FSM, in-frame cycle counter and
// latched pulse width. Direction is only looked at when a frame starts.
// Optional feature macro: MOTOR_RAMP_EN (width slews by RAMP_STEP per frame,
// starting from PULSE_STOP whenever the channel leaves IDLE).
module pwm_channel
  import motor_pkg::*;
#(
  parameter int PERIOD     = DEF_PERIOD,
  parameter int PULSE_FWD  = DEF_PULSE_FWD,
  parameter int PULSE_REV  = DEF_PULSE_REV,
  parameter int PULSE_STOP = DEF_PULSE_STOP,
  parameter int RAMP_STEP  = DEF_RAMP_STEP
) (
  input  logic clk,
  input  logic reset,
  input  logic motor_reset_i,
  input  logic direction_i,
  output logic pwm_o
);

  localparam int PW = $clog2(PERIOD);
  localparam logic [PW-1:0] LAST_CNT = PW'(PERIOD - 1);

  // Catch impossible timing sets at elaboration rather than on the bench.
  if (!((PULSE_REV < PULSE_STOP) && (PULSE_STOP < PULSE_FWD) &&
        (PULSE_FWD < PERIOD) && (PULSE_REV > 0) && (RAMP_STEP > 0))) begin : g_bad_params
    $error("pwm_channel: need 0 < PULSE_REV < PULSE_STOP < PULSE_FWD < PERIOD and RAMP_STEP > 0");
  end

  chan_state_t   state_q, state_d;
  logic [PW-1:0] per_cnt_q, per_cnt_d;
  logic [PW-1:0] width_q, width_d;
  logic          pwm_q;

  logic [PW-1:0] target_width;
  logic [PW-1:0] start_width;  // width of the first frame after leaving IDLE
  logic [PW-1:0] step_width;   // width of each following frame

  assign target_width = direction_i ? PW'(PULSE_FWD) : PW'(PULSE_REV);

`ifdef MOTOR_RAMP_EN
  assign start_width = PW'(PULSE_STOP);
  assign step_width  = PW'(ramp_toward(int'(width_q), int'(target_width), RAMP_STEP));
`else
  assign start_width = target_width;
  assign step_width  = target_width;
`endif

  // Next-state logic: abort on motor_reset beats any frame boundary.
  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    width_d   = width_q;
    unique case (state_q)
      IDLE: begin
        per_cnt_d = '0;
        if (!motor_reset_i) begin
          state_d = HIGH;
          width_d = start_width;
        end
      end
      HIGH: begin
        if (motor_reset_i) begin
          state_d   = IDLE;
          per_cnt_d = '0;
        end else begin
          per_cnt_d = per_cnt_q + PW'(1);
          if (per_cnt_q == (width_q - PW'(1))) begin
            state_d = LOW;
          end
        end
      end
      LOW: begin
        if (motor_reset_i) begin
          state_d   = IDLE;
          per_cnt_d = '0;
        end else if (per_cnt_q == LAST_CNT) begin
          state_d   = HIGH;
          per_cnt_d = '0;
          width_d   = step_width;
        end else begin
          per_cnt_d = per_cnt_q + PW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        per_cnt_d = '0;
      end
    endcase
  end

  // State registers; pwm is registered so it is high exactly while in HIGH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      per_cnt_q <= '0;
      width_q   <= PW'(PULSE_STOP);
      pwm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      width_q   <= width_d;
      pwm_q     <= (state_d == HIGH);
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/motor_pwm_driver.sv
// Servo PWM stage of the line follower: two independent wheel channels plus
// the shared saturating timebase `count` that the controller clears.
// Optional feature macro: MOTOR_RAMP_EN (handled inside pwm_channel).
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int PERIOD     = DEF_PERIOD,
  parameter int PULSE_FWD  = DEF_PULSE_FWD,
  parameter int PULSE_REV  = DEF_PULSE_REV,
  parameter int PULSE_STOP = DEF_PULSE_STOP,
  parameter int RAMP_STEP  = DEF_RAMP_STEP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             count_reset,
  input  logic             motor_l_reset,
  input  logic             motor_l_direction,
  input  logic             motor_r_reset,
  input  logic             motor_r_direction,
  output logic [CNT_W-1:0] count,
  output logic             pwm_l,
  output logic             pwm_r
);

  logic [CNT_W-1:0] count_q, count_d;

  // Channel index 0 = left wheel, 1 = right wheel.
  logic [1:0] chan_off;
  logic [1:0] chan_dir;
  logic [1:0] chan_pwm;

  assign chan_off = {motor_r_reset, motor_l_reset};
  assign chan_dir = {motor_r_direction, motor_l_direction};

  // Timebase increment that sticks at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (count_q != '1) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Timebase register, cleared by global reset or the controller.
  always_ff @(posedge clk) begin
    if (reset || count_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    pwm_channel #(
      .PERIOD     (PERIOD),
      .PULSE_FWD  (PULSE_FWD),
      .PULSE_REV  (PULSE_REV),
      .PULSE_STOP (PULSE_STOP),
      .RAMP_STEP  (RAMP_STEP)
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .motor_reset_i (chan_off[gi]),
      .direction_i   (chan_dir[gi]),
      .pwm_o         (chan_pwm[gi])
    );
  end

  assign count = count_q;
  assign pwm_l = chan_pwm[0];
  assign pwm_r = chan_pwm[1];

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver with a short frame (PERIOD=20, widths 4/2/3, step 1)
// and an 8-bit timebase so saturation is reachable. Expected pulses are queued
// by the stimulus; per-channel monitors pop them on each falling pwm edge.
// Compile with MOTOR_RAMP_EN to exercise the ramped build.
module tb_motor_pwm_driver;

  localparam int CNT_W  = 8;
  localparam int PERIOD = 20;

  typedef struct {
    int width;
    bit chk_gap;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             count_reset;
  logic             motor_l_reset;
  logic             motor_l_direction;
  logic             motor_r_reset;
  logic             motor_r_direction;
  logic [CNT_W-1:0] count;
  logic             pwm_l;
  logic             pwm_r;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t exp_l[$];
  exp_t exp_r[$];

`ifdef MOTOR_RAMP_EN
  localparam int L_N     = 6;
  localparam int R_FIRST = 3;
  int l_w[L_N]   = '{3, 4, 4, 3, 2, 2};
  int l_dir[L_N] = '{-1, -1, 0, -1, -1, -1};
  int l_off[L_N] = '{0, 0, 6, 0, 0, 0};
`else
  localparam int L_N     = 5;
  localparam int R_FIRST = 4;
  int l_w[L_N]   = '{4, 4, 2, 2, 4};
  int l_dir[L_N] = '{-1, 0, -1, 1, -1};
  int l_off[L_N] = '{0, 6, 0, 0, 0};
`endif

  motor_pwm_driver #(
    .CNT_W      (CNT_W),
    .PERIOD     (PERIOD),
    .PULSE_FWD  (4),
    .PULSE_REV  (2),
    .PULSE_STOP (3),
    .RAMP_STEP  (1)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .count_reset       (count_reset),
    .motor_l_reset     (motor_l_reset),
    .motor_l_direction (motor_l_direction),
    .motor_r_reset     (motor_r_reset),
    .motor_r_direction (motor_r_direction),
    .count             (count),
    .pwm_l             (pwm_l),
    .pwm_r             (pwm_r)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit get_pwm(input bit is_r);
    return is_r ? pwm_r : pwm_l;
  endfunction

  task automatic wait_rise(input bit is_r, input string nm);
    int n = 0;
    while (get_pwm(is_r) && n < 60) begin
      @(negedge clk);
      n++;
    end
    while (!get_pwm(is_r) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL %s_rise_timeout actual=no rising edge required=rise within 60 cycles", nm);
    end
  endtask

  // Measures each pulse and its rise-to-rise spacing, then checks them against the queue.
  task automatic monitor_chan(input bit is_r);
    bit    prev = 1'b0;
    bit    cur;
    bit    have_rise = 1'b0;
    int    hi_len = 0;
    int    last_rise = 0;
    int    gap = -1;
    bit    empty;
    exp_t  e;
    string nm = is_r ? "pwm_r" : "pwm_l";
    forever begin
      @(negedge clk);
      cur = get_pwm(is_r);
      if (reset) begin
        prev = 1'b0;
        have_rise = 1'b0;
        hi_len = 0;
        continue;
      end
      if (cur && !prev) begin
        gap = have_rise ? (cyc - last_rise) : -1;
        last_rise = cyc;
        have_rise = 1'b1;
        hi_len = 0;
      end
      if (cur) hi_len++;
      if (!cur && prev) begin
        empty = is_r ? (exp_r.size() == 0) : (exp_l.size() == 0);
        if (empty) begin
          checks = checks + 1;
          failures = failures + 1;
          $display("FAIL %s_unexpected_pulse actual width=%0d required=no pulse", nm, hi_len);
        end else begin
          if (is_r) e = exp_r.pop_front();
          else      e = exp_l.pop_front();
          $display("pulse %s width=%0d gap=%0d expect width=%0d", nm, hi_len, gap, e.width);
          check({nm, "_width"}, hi_len, e.width);
          if (e.chk_gap) check({nm, "_period"}, gap, PERIOD);
        end
      end
      prev = cur;
    end
  endtask

  initial monitor_chan(1'b0);
  initial monitor_chan(1'b1);

  initial begin
    #50000;
    $display("FAIL watchdog actual=still running required=finished by 50000 ns");
    failures = failures + 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    count_reset = 1'b0;
    // Motors enabled while reset is held: reset must still keep everything quiet.
    motor_l_reset = 1'b0;
    motor_r_reset = 1'b0;
    motor_l_direction = 1'b1;
    motor_r_direction = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset_count", count, 0);
      check("reset_pwm_l", pwm_l, 0);
      check("reset_pwm_r", pwm_r, 0);
    end
    motor_l_reset = 1'b1;
    motor_r_reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("count_after_reset", count, 0);
    $display("reset released at cycle %0d", cyc);

    fork
      // Timebase: count-up, controller clear at 57, then saturation.
      begin
        for (int k = 1; k <= 5; k++) begin
          @(negedge clk);
          check("count_up", count, k);
        end
        repeat (52) @(negedge clk);
        check("count_at_57", count, 57);
        count_reset = 1'b1;
        @(negedge clk);
        check("count_cleared", count, 0);
        count_reset = 1'b0;
        @(negedge clk);
        check("count_restart", count, 1);
        repeat (254) @(negedge clk);
        check("count_top", count, 255);
        @(negedge clk);
        check("count_saturated", count, 255);
        $display("timebase sequence done at cycle %0d", cyc);
      end
      // Left wheel: consecutive frames with direction changes at chosen offsets.
      begin
        exp_l.push_back('{width: l_w[0], chk_gap: 1'b0});
        motor_l_direction = 1'b1;
        motor_l_reset = 1'b0;
        for (int n = 0; n < L_N; n++) begin
          wait_rise(1'b0, "pwm_l");
          if (n + 1 < L_N) exp_l.push_back('{width: l_w[n + 1], chk_gap: 1'b1});
          if (l_dir[n] >= 0) begin
            repeat (l_off[n]) @(negedge clk);
            motor_l_direction = l_dir[n][0];
            $display("left direction -> %0d in frame %0d", l_dir[n], n + 1);
          end
        end
        repeat (10) @(negedge clk);
        motor_l_reset = 1'b1;
        repeat (30) @(negedge clk);
        check("pwm_l_off", pwm_l, 0);
      end
      // Right wheel: abort in the second HIGH cycle, then re-enable.
      begin
        exp_r.push_back('{width: R_FIRST, chk_gap: 1'b0});
        motor_r_direction = 1'b1;
        motor_r_reset = 1'b0;
        wait_rise(1'b1, "pwm_r");
        exp_r.push_back('{width: 2, chk_gap: 1'b1});
        wait_rise(1'b1, "pwm_r");
        @(negedge clk);
        motor_r_reset = 1'b1;
        $display("right abort at cycle %0d", cyc);
        repeat (25) @(negedge clk);
        check("pwm_r_held_off", pwm_r, 0);
        exp_r.push_back('{width: R_FIRST, chk_gap: 1'b0});
        motor_r_reset = 1'b0;
        wait_rise(1'b1, "pwm_r");
        repeat (10) @(negedge clk);
        motor_r_reset = 1'b1;
        repeat (30) @(negedge clk);
        check("pwm_r_off", pwm_r, 0);
      end
    join

    repeat (5) @(negedge clk);
    check("pwm_l_pending", exp_l.size(), 0);
    check("pwm_r_pending", exp_r.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
